guass_frm_sched: RTL and testbench
==================================

# guass_frm_sched

Frame scheduler sequencing the Gaussian filter input port. Pulls pixels from an upstream ready/valid source (frame buffer reader or DMA FIFO) and emits the pvsync/pvde/pdata raster the filter expects: vsync pulse, post-vsync gap, active lines with fixed horizontal blanking, then trailing flush lines so the filter's line buffers drain the last rows. Sits directly in front of `guassflt`.

## Interface
- VS_LEN, 10, pvsync high cycles
- VS_POST, 10, idle cycles between pvsync fall and first active line
- HBLANK, 200, idle cycles after each active line (also used in flush lines)
- FLUSH_LINES, 4, trailing lines of pvde=0 after the last active line
- PIX_W, 16, pixel width ({Y,UV})

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-high
- frm_width  in  11  pixels per line minus 1 (1919 for 1080p)
- frm_height  in  11  lines per frame minus 1
- start  in  1  one-cycle request to schedule one frame
- src_valid  in  1  source pixel valid
- src_data  in  PIX_W  source pixel
- src_ready  out  1  pixel accepted when src_valid & src_ready
- pvsync  out  1  to filter
- pvde  out  1  to filter
- pdata  out  PIX_W  to filter
- busy  out  1  high in any state except IDLE
- frm_done  out  1  one-cycle pulse at end of flush
- underrun  out  1  sticky: source starved during an active line

## Operation
- Reset: state IDLE; pvsync=0, pvde=0, pdata=0, src_ready=0, busy=0, frm_done=0, underrun=0; all counters 0.
- States: IDLE -> VSYNC -> VPOST -> ACTIVE <-> HBLK -> FLUSH -> DONE -> IDLE.
- IDLE: on start, latch frm_width/frm_height into shadow regs, clear underrun, go VSYNC. Width/height changes after latch ignored until next frame.
- VSYNC: VS_LEN cycles, then VPOST. VPOST: VS_POST cycles, then ACTIVE (y=0).
- ACTIVE: exactly width+1 cycles (x=0..width); src_ready=1 every cycle. Raster never stalls.
- Accepted pixel -> pdata=src_data. Cycle with src_valid=0 -> pdata=0, pvde still 1, underrun set (sticky).
- End of line: HBLK for HBLANK cycles; then ACTIVE with y+1 if y<height, else FLUSH.
- FLUSH: FLUSH_LINES × (width+1+HBLANK) cycles, pvde=0, then DONE.
- DONE: one cycle, frm_done=1, go IDLE.
- start while busy: ignored, no queueing.
- Counters: x, y 11-bit compared by equality with shadow regs; blank/flush counter 16-bit. frm_width=0 is legal (1-pixel lines).

## Timing
- pvsync, pvde, pdata, frm_done registered; src_ready and busy decoded from current state.
- start sampled at edge T -> state VSYNC after T; pvsync high for cycles T+1..T+VS_LEN.
- First ACTIVE cycle = T+1+VS_LEN+VS_POST; src_ready high from that cycle.
- Pixel accepted in cycle N appears on pdata with pvde=1 in cycle N+1 (latency 1). pvde trails src_ready by one cycle, same width+1 length.
- Line period = width+1+HBLANK cycles. Frame, start to frm_done: 1+VS_LEN+VS_POST+(height+1+FLUSH_LINES)(width+1+HBLANK)+1 cycles.
- rstn mid-frame: all outputs return to reset values immediately (async); no partial-line completion.

## Configuration
- GUASS_FRM_SCHED_AUTORESTART_EN defined: DONE goes straight to VSYNC (re-latching frm_width/frm_height, clearing underrun) without start; frm_done still pulses; busy stays high; start ignored.
- Not defined: DONE returns to IDLE; each frame needs start.

## Test plan
- Reset then idle: rstn=1 for 5 cycles, start=0 -> all outputs 0, src_ready=0 for 100 cycles.
- Small frame: VS_LEN=10, VS_POST=10, HBLANK=200, width=7, height=3, source always valid, incrementing data -> pvsync 10 cycles, 4 lines of 8 pvde cycles with data 0..31 in order, 208-cycle line period, 4 flush lines, frm_done at exactly the cycle count above.
- Starvation: drop src_valid for pixel 3 of line 1 -> pdata=0 with pvde=1 at that slot, underrun=1 to end of frame, line timing unchanged.
- Busy start: pulse start mid-ACTIVE -> no effect; second frame only after start in IDLE; width change mid-frame ignored.
- Async reset at line 2 pixel 5 -> pvde/pvsync/busy low immediately; next start yields a clean full frame.
- Macro defined: one start, width=7, height=1 -> back-to-back frames, second pvsync begins the cycle after frm_done; without macro, busy=0 after frm_done.

Source files
------------

// File: rtl/guass_frm_sched.sv
// Frame scheduler feeding the Gaussian filter: vsync, post-vsync gap, active lines with fixed
// blanking, then flush lines. Optional build macro GUASS_FRM_SCHED_AUTORESTART_EN chains frames back to back.
module guass_frm_sched #(
  parameter int VS_LEN      = 10,
  parameter int VS_POST     = 10,
  parameter int HBLANK      = 200,
  parameter int FLUSH_LINES = 4,
  parameter int PIX_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [10:0]      frm_width,
  input  logic [10:0]      frm_height,
  input  logic             start,
  input  logic             src_valid,
  input  logic [PIX_W-1:0] src_data,
  output logic             src_ready,
  output logic             pvsync,
  output logic             pvde,
  output logic [PIX_W-1:0] pdata,
  output logic             busy,
  output logic             frm_done,
  output logic             underrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VPOST  = 3'd2,
    ACTIVE = 3'd3,
    HBLK   = 3'd4,
    FLUSH  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [15:0] VS_LAST = 16'(VS_LEN - 1);
  localparam logic [15:0] VP_LAST = 16'(VS_POST - 1);
  localparam logic [15:0] HB_LAST = 16'(HBLANK - 1);
  localparam logic [10:0] FL_LAST = 11'(FLUSH_LINES - 1);

  state_t      state_r, state_s;
  logic [10:0] wid_r, wid_s, hgt_r, hgt_s;
  logic [10:0] x_r, x_s, y_r, y_s;
  logic [15:0] cnt_r, cnt_s;
  logic [15:0] line_last_s;
  logic        underrun_r, underrun_s;
  logic        pvsync_r, pvde_r, frm_done_r;
  logic [PIX_W-1:0] pdata_r;

  // Flush lines last as long as a full raster line; y doubles as the flush-line index there.
  assign line_last_s = {5'd0, wid_r} + 16'(HBLANK);

  // Next-state, counter and shadow-register logic.
  always_comb begin
    state_s    = state_r;
    wid_s      = wid_r;
    hgt_s      = hgt_r;
    x_s        = x_r;
    y_s        = y_r;
    cnt_s      = cnt_r;
    underrun_s = underrun_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          wid_s      = frm_width;
          hgt_s      = frm_height;
          underrun_s = 1'b0;
          cnt_s      = 16'd0;
          state_s    = VSYNC;
        end else begin
          state_s = IDLE;
        end
      end
      VSYNC: begin
        if (cnt_r == VS_LAST) begin
          cnt_s   = 16'd0;
          state_s = VPOST;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      VPOST: begin
        if (cnt_r == VP_LAST) begin
          cnt_s   = 16'd0;
          x_s     = 11'd0;
          y_s     = 11'd0;
          state_s = ACTIVE;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ACTIVE: begin
        if (!src_valid) begin
          underrun_s = 1'b1;
        end else begin
          underrun_s = underrun_r;
        end
        if (x_r == wid_r) begin
          x_s     = 11'd0;
          cnt_s   = 16'd0;
          state_s = HBLK;
        end else begin
          x_s = x_r + 11'd1;
        end
      end
      HBLK: begin
        if (cnt_r == HB_LAST) begin
          cnt_s = 16'd0;
          if (y_r == hgt_r) begin
            y_s     = 11'd0;
            state_s = FLUSH;
          end else begin
            y_s     = y_r + 11'd1;
            state_s = ACTIVE;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      FLUSH: begin
        if (cnt_r == line_last_s) begin
          cnt_s = 16'd0;
          if (y_r == FL_LAST) begin
            y_s     = 11'd0;
            state_s = DONE;
          end else begin
            y_s = y_r + 11'd1;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      DONE: begin
`ifdef GUASS_FRM_SCHED_AUTORESTART_EN
        wid_s      = frm_width;
        hgt_s      = frm_height;
        underrun_s = 1'b0;
        cnt_s      = 16'd0;
        state_s    = VSYNC;
`else
        state_s = IDLE;
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and shadow registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_r    <= IDLE;
      wid_r      <= 11'd0;
      hgt_r      <= 11'd0;
      x_r        <= 11'd0;
      y_r        <= 11'd0;
      cnt_r      <= 16'd0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      wid_r      <= wid_s;
      hgt_r      <= hgt_s;
      x_r        <= x_s;
      y_r        <= y_s;
      cnt_r      <= cnt_s;
      underrun_r <= underrun_s;
    end
  end

  // Registered raster outputs: vsync/done track the next state, pixel path lags ACTIVE by one cycle.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pvsync_r   <= 1'b0;
      pvde_r     <= 1'b0;
      pdata_r    <= {PIX_W{1'b0}};
      frm_done_r <= 1'b0;
    end else begin
      pvsync_r   <= (state_s == VSYNC);
      pvde_r     <= (state_r == ACTIVE);
      pdata_r    <= ((state_r == ACTIVE) && src_valid) ? src_data : {PIX_W{1'b0}};
      frm_done_r <= (state_s == DONE);
    end
  end

  assign src_ready = (state_r == ACTIVE);
  assign busy      = (state_r != IDLE);
  assign pvsync    = pvsync_r;
  assign pvde      = pvde_r;
  assign pdata     = pdata_r;
  assign frm_done  = frm_done_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_guass_frm_sched.sv
// Self-checking bench for guass_frm_sched: table of frames checked cycle by cycle against an
// arithmetic raster model (position derived from offset since start), plus reset/idle sequences.
module tb_guass_frm_sched;
  localparam int VS_LEN = 10, VS_POST = 10, HBLANK = 200, FLUSH_LINES = 4, PIX_W = 16;

  logic clk = 1'b0;
  logic rstn, start, src_valid;
  logic [PIX_W-1:0] src_data, pdata;
  logic [10:0] frm_width, frm_height;
  logic src_ready, pvsync, pvde, busy, frm_done, underrun;

  int tests = 0;
  int fails = 0;
  logic [PIX_W-1:0] pix = 16'd0;

  always #5 clk = ~clk;

  guass_frm_sched #(.VS_LEN(VS_LEN), .VS_POST(VS_POST), .HBLANK(HBLANK),
                    .FLUSH_LINES(FLUSH_LINES), .PIX_W(PIX_W)) dut (
    .clk(clk), .rstn(rstn), .frm_width(frm_width), .frm_height(frm_height),
    .start(start), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .pvsync(pvsync), .pvde(pvde), .pdata(pdata), .busy(busy),
    .frm_done(frm_done), .underrun(underrun));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [21:0] out_vec();
    return {pvsync, pvde, busy, src_ready, frm_done, underrun, pdata};
  endfunction

  // Where cycle k (k=1 is the cycle after start is sampled) falls in the frame raster.
  function automatic void frame_pos(input int k, input int w, input int h,
                                    output logic pvs, output logic act, output logic bsy,
                                    output logic dn, output logic first);
    int lp, a0, dk, kk, off;
    lp = w + 1 + HBLANK;
    a0 = 1 + VS_LEN + VS_POST;
    dk = a0 + (h + 1 + FLUSH_LINES) * lp;
    kk = k;
`ifdef GUASS_FRM_SCHED_AUTORESTART_EN
    kk = ((k - 1) % dk) + 1;
    bsy = 1'b1;
`else
    bsy = (kk <= dk);
`endif
    off = kk - a0;
    pvs = (kk >= 1) && (kk <= VS_LEN);
    first = (kk == 1);
    act = (kk >= a0) && (off / lp <= h) && (off % lp <= w);
    dn = (kk == dk);
  endfunction

  task automatic run_frame(input int w, input int h, input int mode, input int poke_k,
                           input int abort_k, output int frm_cnt, output int pix_cnt,
                           output logic ur_end);
    int lp, a0, dk, end_k;
    logic pvs, act, bsy, dn, first, v, p_act, p_v, ur_m;
    logic [PIX_W-1:0] p_d;
    logic [21:0] expv;
    lp = w + 1 + HBLANK;
    a0 = 1 + VS_LEN + VS_POST;
    dk = a0 + (h + 1 + FLUSH_LINES) * lp;
    end_k = dk + 3;
`ifdef GUASS_FRM_SCHED_AUTORESTART_EN
    end_k = 2 * dk + 3;
`endif
    frm_cnt = 0; pix_cnt = 0; ur_end = 1'b0;
    p_act = 1'b0; p_v = 1'b0; p_d = 16'd0; ur_m = 1'b0;
    frm_width = 11'(w); frm_height = 11'(h); src_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifndef GUASS_FRM_SCHED_AUTORESTART_EN
    frm_width = 11'($urandom_range(0, 2047));
    frm_height = 11'($urandom_range(0, 2047));
`endif
    for (int k = 1; k <= end_k; k++) begin
      frame_pos(k, w, h, pvs, act, bsy, dn, first);
      if (k == abort_k) begin
        rstn = 1'b1; #1;
        check("async_reset", 32'(out_vec()), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b0;
        ur_end = underrun;
        return;
      end
      case (mode)
        0: v = 1'b1;
        1: v = (k == a0) ? 1'b0 : ($urandom_range(0, 7) != 0);
        2: v = !(k >= a0 && (k - a0) / lp == 1 && (k - a0) % lp == 3);
        default: v = 1'b1;
      endcase
      src_valid = v;
      src_data = v ? pix : PIX_W'($urandom);
      start = (k == poke_k);
      if (first) ur_m = 1'b0;
      @(negedge clk);
      expv = {pvs, p_act, bsy, act, dn, ur_m, (p_act && p_v) ? p_d : {PIX_W{1'b0}}};
      check($sformatf("raster k=%0d", k), 32'(out_vec()), 32'(expv));
      if (frm_done && frm_cnt == 0) frm_cnt = k + 1;
      if (pvde && k <= dk) pix_cnt++;
      if (k == dk) ur_end = underrun;
      if (act && !v) ur_m = 1'b1;
      if (act && v) pix = pix + 16'd1;
      p_act = act; p_v = v; p_d = src_data;
      @(posedge clk); #1;
    end
    start = 1'b0;
    src_valid = 1'b0;
  endtask

  typedef struct {
    int w; int h; int mode; int poke_k; int abort_k;
    int exp_frm; int exp_pix; logic exp_ur;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int frm_cnt, pix_cnt;
    logic ur_end;
    vecs[0] = '{7, 3, 0, 0, 0, 1686, 32, 1'b0};
    vecs[1] = '{0, 0, 0, 0, 0, 1027, 1, 1'b0};
    vecs[2] = '{7, 3, 2, 231, 0, 1686, 32, 1'b1};
    vecs[3] = '{7, 3, 0, 0, 442, 0, 20, 1'b0};
    vecs[4] = '{7, 3, 0, 0, 0, 1686, 32, 1'b0};
    vecs[5] = '{15, 2, 1, 100, 0, 1534, 48, 1'b1};
    vecs[6] = '{7, 1, 0, 0, 0, 1270, 16, 1'b0};

    rstn = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = 16'd0;
    frm_width = 11'd0; frm_height = 11'd0;
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("idle c=%0d", i), 32'(out_vec()), 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].mode, vecs[i].poke_k, vecs[i].abort_k,
                frm_cnt, pix_cnt, ur_end);
      check($sformatf("frm_cycles v%0d", i), 32'(frm_cnt), 32'(vecs[i].exp_frm));
      check($sformatf("pix_count v%0d", i), 32'(pix_cnt), 32'(vecs[i].exp_pix));
      check($sformatf("underrun v%0d", i), 32'(ur_end), 32'(vecs[i].exp_ur));
`ifdef GUASS_FRM_SCHED_AUTORESTART_EN
      rstn = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b0;
`endif
    end

    for (int i = 0; i < 3; i++) begin
      int w, h;
      w = $urandom_range(0, 20);
      h = $urandom_range(0, 2);
      run_frame(w, h, 1, 0, 0, frm_cnt, pix_cnt, ur_end);
      check($sformatf("rnd_frm_cycles %0d", i), 32'(frm_cnt),
            32'(2 + VS_LEN + VS_POST + (h + 1 + FLUSH_LINES) * (w + 1 + HBLANK)));
      check($sformatf("rnd_pix_count %0d", i), 32'(pix_cnt), 32'((w + 1) * (h + 1)));
      check($sformatf("rnd_underrun %0d", i), 32'(ur_end), 32'd1);
`ifdef GUASS_FRM_SCHED_AUTORESTART_EN
      rstn = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b0;
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
